timer_multi: RTL and testbench

- Parametrised multi-channel programmable timer. Successor to the single-channel timer on the MINI_MACHINE peripheral bus.
- Sits behind the bridge as one addressable device. Each channel has a down-counter that runs in one-shot or periodic mode and raises a maskable interrupt toward CP0.
- Adds per-channel state machines, W1C interrupt status and an OR-reduced interrupt line.

---
 rtl/timer_multi.sv | 166 ++++++++++++++++
 tb/tb_timer_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: multi-channel programmable down-counter timer on the peripheral bus.
// Each channel runs one-shot or periodic, latches a W1C pending flag on expiry
// and drives a maskable interrupt; irq_any ORs all channel interrupts.
module timer_multi #(
   parameter int NUM_CH = 2,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);

   localparam int CH_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      DONE = 2'd3
   } state_t;

   logic [CH_W-1:0] ch_sel;
   logic [1:0]      reg_sel;

   assign ch_sel  = addr[ADDR_W-1:2];
   assign reg_sel = addr[1:0];

   // Per-channel register views, zero-extended to the bus width for the read mux.
   logic [31:0] ctrl_rd   [NUM_CH];
   logic [31:0] preset_rd [NUM_CH];
   logic [31:0] count_rd  [NUM_CH];
   logic [31:0] status_rd [NUM_CH];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t            state_reg, state_next;
      logic              en_reg, en_next;
      logic              mode_reg, mode_next;
      logic              im_reg, im_next;
      logic              pend_reg, pend_next;
      logic [WIDTH-1:0]  preset_reg, preset_next;
      logic [WIDTH-1:0]  count_reg, count_next;
      logic              sel, wr_ctrl, wr_preset, wr_status, en_rise;

      assign sel       = (ch_sel == CH_W'(gi));
      assign wr_ctrl   = we && sel && (reg_sel == 2'd0);
      assign wr_preset = we && sel && (reg_sel == 2'd1);
      assign wr_status = we && sel && (reg_sel == 2'd3);
      // An enabling write is one that turns en from 0 to 1.
      assign en_rise   = wr_ctrl && wdata[0] && !en_reg;

      // Bus writes first, then FSM effects; later assignments take priority so a
      // hardware pending set beats a same-edge W1C, and one-shot expiry clears en.
      always_comb begin
         state_next  = state_reg;
         en_next     = en_reg;
         mode_next   = mode_reg;
         im_next     = im_reg;
         pend_next   = pend_reg;
         preset_next = preset_reg;
         count_next  = count_reg;

         if (wr_ctrl) begin
            en_next   = wdata[0];
            mode_next = wdata[1];
            im_next   = wdata[3];
         end
         if (wr_preset) begin
            preset_next = wdata[WIDTH-1:0];
         end
         if (wr_status && wdata[0]) begin
            pend_next = 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (wr_preset || en_rise) begin
                  state_next = LOAD;
               end
            end
            LOAD: begin
               count_next = preset_reg;
               // An enable arriving during LOAD restarts the load so the
               // enable-to-expiry latency stays the same as from IDLE.
               if (en_rise) begin
                  state_next = LOAD;
               end else if (en_reg) begin
                  state_next = CNT;
               end else begin
                  state_next = IDLE;
               end
            end
            CNT: begin
               if (!en_reg) begin
                  state_next = IDLE;
               end else if (count_reg > WIDTH'(1)) begin
                  count_next = count_reg - WIDTH'(1);
               end else begin
                  count_next = '0;
                  pend_next  = 1'b1;
                  state_next = DONE;
               end
            end
            DONE: begin
               if (mode_reg) begin
                  state_next = LOAD;
               end else begin
                  en_next    = 1'b0;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end

      // Channel state register with synchronous reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_reg  <= IDLE;
            en_reg     <= 1'b0;
            mode_reg   <= 1'b0;
            im_reg     <= 1'b0;
            pend_reg   <= 1'b0;
            preset_reg <= '0;
            count_reg  <= '0;
         end else begin
            state_reg  <= state_next;
            en_reg     <= en_next;
            mode_reg   <= mode_next;
            im_reg     <= im_next;
            pend_reg   <= pend_next;
            preset_reg <= preset_next;
            count_reg  <= count_next;
         end
      end

      assign irq[gi]       = pend_reg & im_reg;
      assign ctrl_rd[gi]   = {28'd0, im_reg, 1'b0, mode_reg, en_reg};
      assign preset_rd[gi] = 32'(preset_reg);
      assign count_rd[gi]  = 32'(count_reg);
      assign status_rd[gi] = {31'd0, pend_reg};
   end

   assign irq_any = |irq;

   // Combinational read mux; unmapped channel indices read as zero.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == CH_W'(i)) begin
            case (reg_sel)
               2'd0:    rdata = ctrl_rd[i];
               2'd1:    rdata = preset_rd[i];
               2'd2:    rdata = count_rd[i];
               default: rdata = status_rd[i];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: directed self-checking bench for timer_multi (NUM_CH=2).
module tb_timer_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [1:0]  irq;
   logic        irq_any;

   int checks = 0;
   int errors = 0;

   timer_multi #(.NUM_CH(2), .WIDTH(32), .ADDR_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .we      (we),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq     (irq),
      .irq_any (irq_any)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check_val(tag, rdata, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; addr = '0; we = 1'b0; wdata = '0;
      tick(2);
      rst = 1'b0;

      // Reset mid-activity.
      wr(4'h1, 32'd7);
      wr(4'h5, 32'd3);
      wr(4'h0, 32'h9);
      wr(4'h4, 32'hB);
      tick(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int a = 0; a < 8; a++) begin
         check_reg($sformatf("rst_reg%0d", a), 4'(a), 32'd0);
         if (a % 4 == 3) tick();
      end
      check_val("rst_irq", 32'(irq), 32'd0);
      check_val("rst_irq_any", 32'(irq_any), 32'd0);
      tick(3);
      check_reg("rst_idle_count0", 4'h2, 32'd0);

      // One-shot, ch0: P=5, expiry six edges after the enabling write.
      wr(4'h1, 32'd5);
      tick();
      check_reg("os_preload", 4'h2, 32'd5);
      wr(4'h0, 32'h9);
      check_val("os_irq_e0", 32'(irq[0]), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         check_reg($sformatf("os_count_e%0d", k), 4'h2, 32'(6 - k));
         check_val($sformatf("os_irq_e%0d", k), 32'(irq[0]), (k == 6) ? 32'd1 : 32'd0);
      end
      tick();
      check_reg("os_ctrl_after", 4'h0, 32'h8);
      tick(2);
      check_reg("os_count_hold", 4'h2, 32'd0);
      check_val("os_irq_hold", 32'(irq[0]), 32'd1);
      wr(4'h3, 32'd1);
      check_val("os_irq_cleared", 32'(irq[0]), 32'd0);
      check_reg("os_status_cleared", 4'h3, 32'd0);

      // COUNT is read-only.
      wr(4'h2, 32'h55);
      check_reg("count_ro", 4'h2, 32'd0);

      // Periodic, ch1: P=3, pending every 5 cycles (E4, E9, E14).
      wr(4'h5, 32'd3);
      tick();
      wr(4'h4, 32'hB);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_val($sformatf("per_irq_e%0d", k), 32'(irq[1]), (k == 4) ? 32'd1 : 32'd0);
      end
      check_val("per_irq_any", 32'(irq_any), 32'd1);
      wr(4'h7, 32'd1);
      check_val("per_w1c", 32'(irq[1]), 32'd0);
      for (int k = 6; k <= 9; k++) begin
         tick();
         check_val($sformatf("per_irq_e%0d", k), 32'(irq[1]), (k == 9) ? 32'd1 : 32'd0);
      end
      wr(4'h7, 32'd0);
      check_val("per_w0_noeffect", 32'(irq[1]), 32'd1);
      check_reg("per_status_w0", 4'h7, 32'd1);
      wr(4'h7, 32'd1);
      check_val("per_w1c_2", 32'(irq[1]), 32'd0);
      tick(2);
      check_reg("col_count_before", 4'h6, 32'd1);
      // W1C on the same edge that COUNT goes 1->0: the set wins.
      wr(4'h7, 32'd1);
      check_val("col_irq", 32'(irq[1]), 32'd1);
      check_reg("col_status", 4'h7, 32'd1);
      wr(4'h4, 32'h0);
      tick(2);
      wr(4'h7, 32'd1);
      tick(2);
      check_val("per_stopped_irq_any", 32'(irq_any), 32'd0);

      // Disable mid-count, ch0: P=10.
      wr(4'h1, 32'd10);
      tick();
      wr(4'h0, 32'h9);
      tick(5);
      check_reg("dis_count6", 4'h2, 32'd6);
      wr(4'h0, 32'h8);
      check_reg("dis_count_edge", 4'h2, 32'd5);
      tick(4);
      check_reg("dis_count_hold", 4'h2, 32'd5);
      check_val("dis_no_irq", 32'(irq[0]), 32'd0);
      wr(4'h0, 32'h9);
      tick();
      check_reg("dis_reload", 4'h2, 32'd10);
      wr(4'h0, 32'h8);
      tick(2);

      // Masked expiry, ch0: P=2, im=0.
      wr(4'h1, 32'd2);
      tick();
      wr(4'h0, 32'h1);
      tick(4);
      check_reg("mask_status", 4'h3, 32'd1);
      check_val("mask_irq", 32'(irq[0]), 32'd0);
      check_val("mask_irq_any", 32'(irq_any), 32'd0);
      wr(4'h0, 32'h8);
      check_val("unmask_irq", 32'(irq[0]), 32'd1);
      check_val("unmask_irq_any", 32'(irq_any), 32'd1);

      // Out-of-range channel index 2.
      wr(4'h9, 32'h1234);
      wr(4'h8, 32'h9);
      for (int a = 8; a < 12; a++) begin
         check_reg($sformatf("oor_reg%0d", a), 4'(a), 32'd0);
      end
      tick();
      check_reg("oor_ch0_preset", 4'h1, 32'd2);
      check_reg("oor_ch1_preset", 4'h5, 32'd3);
      check_reg("oor_ch1_ctrl", 4'h4, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
